// File: rtl/fram_wb_if.sv
// Bus bundle between the CU/decoder side and the FRAM write-back queue:
// result write handshake, decoder read probe and the bank write port.
interface fram_wb_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_NUM   = 4
);
  localparam int BANK_BITS       = $clog2(BANK_NUM);
  localparam int BANK_ADDR_WIDTH = ADDR_WIDTH - BANK_BITS;

  // Handshake: a result transfers on a clk edge where wr_valid && wr_ready.
  // wr_ready depends only on registered queue state, never on wr_valid or rd_*.
  logic                       wr_valid;
  logic                       wr_ready;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic                       rd_valid;
  logic [ADDR_WIDTH-1:0]      rd_addr;
  logic                       rd_hazard;
  logic [BANK_NUM-1:0]        bank_we;
  logic [BANK_ADDR_WIDTH-1:0] bank_addr;
  logic [DATA_WIDTH-1:0]      bank_wdata;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_hazard, bank_we, bank_addr, bank_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_hazard, bank_we, bank_addr, bank_wdata
  );
endinterface

// File: rtl/fram_wb_queue.sv
// In-order write-back queue from the CU result port to FRAM port B. The head
// write yields to a same-bank decoder read; reads hitting queued writes flag RAW.
module fram_wb_queue #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_NUM   = 4,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fram_wb_if.slave                 bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic [15:0]              stall_cnt,
  output logic                     err_ovf,
  input  logic                     err_clr
);
  localparam int BANK_BITS       = $clog2(BANK_NUM);
  localparam int BANK_ADDR_WIDTH = ADDR_WIDTH - BANK_BITS;
  localparam int PTR_W           = $clog2(DEPTH);
  localparam int CNT_W           = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;

  logic                  full;
  logic                  push;
  logic                  retire;
  logic                  conflict;
  logic [BANK_BITS-1:0]  head_bank;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic                  hazard;
  logic [PTR_W-1:0]      offs;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign push      = bus.wr_valid && !full;
  assign head_addr = addr_mem[rd_ptr];
  assign head_bank = head_addr[BANK_BITS-1:0];
  assign conflict  = bus.rd_valid && (bus.rd_addr[BANK_BITS-1:0] == head_bank);
  assign retire    = !empty && !conflict;

  assign bus.wr_ready   = !full;
  assign bus.bank_we    = retire ? ({{(BANK_NUM-1){1'b0}}, 1'b1} << head_bank) : '0;
  assign bus.bank_addr  = head_addr[ADDR_WIDTH-1:BANK_BITS];
  assign bus.bank_wdata = data_mem[rd_ptr];
  assign bus.rd_hazard  = hazard;

  // An entry is live when its distance from the head is below the occupancy;
  // the head still counts while it is being written this cycle.
  always_comb begin
    hazard = 1'b0;
    offs   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr;
      if (bus.rd_valid && ({1'b0, offs} < count_q) && (addr_mem[i] == bus.rd_addr))
        hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.wr_addr;
      data_mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;
      if (push && !retire)      count_q <= count_q + 1'b1;
      else if (!push && retire) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      err_ovf   <= 1'b0;
    end else begin
      if (err_clr)
        stall_cnt <= '0;
      else if (!empty && !retire && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      // A new overflow in the clearing cycle keeps the flag set.
      if (bus.wr_valid && !full)
        err_ovf <= err_ovf && !err_clr;
      else if (bus.wr_valid)
        err_ovf <= 1'b1;
      else if (err_clr)
        err_ovf <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{BANK_ADDR_WIDTH'(0)};
endmodule

// File: tb/tb_fram_wb_queue.sv
// Bench for fram_wb_queue: directed scenarios plus randomized traffic checked
// against a queue-based model of the write-back rules.
module tb_fram_wb_queue;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BN = 4;
  localparam int DP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err_clr;
  logic [3:0]  count;
  logic        empty;
  logic [15:0] stall_cnt;
  logic        err_ovf;

  fram_wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN)) bus();

  fram_wb_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .count(count), .empty(empty),
    .stall_cnt(stall_cnt), .err_ovf(err_ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending writes in program order, plus error/stall state.
  logic [AW-1:0] exp_a[$];
  logic [DW-1:0] exp_q[$];
  int            m_stall;
  logic          m_ovf;

  function automatic logic [1:0] bank_of(input logic [AW-1:0] a);
    return a[1:0];
  endfunction

  function automatic logic m_retire();
    if (exp_a.size() == 0) return 1'b0;
    return !(bus.rd_valid && (bank_of(bus.rd_addr) == bank_of(exp_a[0])));
  endfunction

  function automatic logic m_hazard();
    logic h = 1'b0;
    foreach (exp_a[i]) if (bus.rd_valid && exp_a[i] == bus.rd_addr) h = 1'b1;
    return h;
  endfunction

  task automatic model_clear();
    exp_a.delete();
    exp_q.delete();
    m_stall = 0;
    m_ovf   = 1'b0;
  endtask

  // Advance the model with the inputs presented this cycle, then take the edge.
  task automatic tick();
    logic ret, full;
    ret  = m_retire();
    full = (exp_a.size() == DP);
    if (bus.wr_valid && full) m_ovf = 1'b1;
    else if (err_clr)         m_ovf = 1'b0;
    if (err_clr) m_stall = 0;
    else if (exp_a.size() > 0 && !ret && m_stall < 65535) m_stall++;
    if (ret) begin
      void'(exp_a.pop_front());
      void'(exp_q.pop_front());
    end
    if (bus.wr_valid && !full) begin
      exp_a.push_back(bus.wr_addr);
      exp_q.push_back(bus.wr_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_valid = 1'b0;
    bus.rd_addr  = '0;
    err_clr      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    model_clear();
    #12;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", bus.wr_ready); end
    checks++; if (bus.bank_we !== 4'b0) begin errors++; $display("FAIL reset_bank_we got=%b exp=0000", bus.bank_we); end
    checks++; if (bus.rd_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%b exp=0", bus.rd_hazard); end
    checks++; if (stall_cnt !== 16'd0 || err_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_err got stall=%0d ovf=%b exp 0/0", stall_cnt, err_ovf); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.wr_valid = 1'b1; bus.wr_addr = 14'h005; bus.wr_data = 32'hA5;
    #2;
    checks++; if (bus.bank_we !== 4'b0) begin errors++; $display("FAIL single_no_bypass got=%b exp=0000", bus.bank_we); end
    tick();
    bus.wr_valid = 1'b0;
    #2;
    checks++; if (bus.bank_we !== 4'b0010) begin errors++; $display("FAIL single_we got=%b exp=0010", bus.bank_we); end
    checks++; if (bus.bank_addr !== 12'd1) begin errors++; $display("FAIL single_addr got=%0h exp=1", bus.bank_addr); end
    checks++; if (bus.bank_wdata !== 32'hA5) begin errors++; $display("FAIL single_data got=%0h exp=a5", bus.bank_wdata); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b exp=1", empty); end
  endtask

  task automatic test_conflict();
    bus.wr_valid = 1'b1; bus.wr_addr = 14'h004; bus.wr_data = 32'h44;
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_addr = 14'h010;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (bus.bank_we !== 4'b0) begin errors++; $display("FAIL conflict_hold%0d got=%b exp=0000", k, bus.bank_we); end
      tick();
    end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL conflict_stall got=%0d exp=3", stall_cnt); end
    bus.rd_valid = 1'b0;
    #2;
    checks++; if (bus.bank_we !== 4'b0001) begin errors++; $display("FAIL conflict_release got=%b exp=0001", bus.bank_we); end
    tick();
  endtask

  task automatic test_full();
    logic [AW-1:0] la[$];
    logic [DW-1:0] ld[$];
    bus.rd_valid = 1'b1; bus.rd_addr = 14'h000;
    for (int k = 0; k < DP; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = (k == 0) ? 14'h100 : AW'($urandom_range(1, 16383));
      bus.wr_data  = $urandom;
      la.push_back(bus.wr_addr);
      ld.push_back(bus.wr_data);
      tick();
    end
    #2;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", count); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", bus.wr_ready); end
    bus.wr_addr = 14'h3FF; bus.wr_data = 32'hDEAD;
    tick();
    bus.wr_valid = 1'b0;
    #2;
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL full_ovf got=%b exp=1", err_ovf); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count_hold got=%0d exp=8", count); end
    bus.rd_valid = 1'b0;
    for (int k = 0; k < DP; k++) begin
      #2;
      checks++; if (bus.bank_we !== (4'b0001 << la[k][1:0]) || bus.bank_addr !== la[k][AW-1:2] ||
                    bus.bank_wdata !== ld[k]) begin
        errors++; $display("FAIL full_drain%0d got we=%b a=%0h d=%0h exp we=%b a=%0h d=%0h", k,
          bus.bank_we, bus.bank_addr, bus.bank_wdata, 4'b0001 << la[k][1:0], la[k][AW-1:2], ld[k]); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty got=%b exp=1", empty); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_ovf !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL full_clr got ovf=%b stall=%0d exp 0/0", err_ovf, stall_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] la[20];
    logic [DW-1:0] ld[20];
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
        la[i] = AW'($urandom);
        ld[i] = $urandom;
        bus.wr_valid = 1'b1; bus.wr_addr = la[i]; bus.wr_data = ld[i];
      end else begin
        bus.wr_valid = 1'b0;
      end
      #2;
      checks++; if (count > 4'd1 || bus.wr_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_occ%0d got count=%0d ready=%b exp <=1/1", i, count, bus.wr_ready); end
      if (i > 0) begin
        checks++; if (bus.bank_we !== (4'b0001 << la[i-1][1:0]) || bus.bank_addr !== la[i-1][AW-1:2] ||
                      bus.bank_wdata !== ld[i-1]) begin
          errors++; $display("FAIL b2b_write%0d got we=%b a=%0h d=%0h exp we=%b a=%0h d=%0h", i-1,
            bus.bank_we, bus.bank_addr, bus.bank_wdata, 4'b0001 << la[i-1][1:0], la[i-1][AW-1:2], ld[i-1]); end
      end
      tick();
    end
  endtask

  task automatic test_hazard();
    bus.wr_valid = 1'b1; bus.wr_addr = 14'h123; bus.wr_data = 32'h0123_4567;
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_addr = 14'h123;
    #2;
    checks++; if (bus.rd_hazard !== 1'b1) begin errors++; $display("FAIL hazard_hit got=%b exp=1", bus.rd_hazard); end
    bus.rd_addr = 14'h124;
    #2;
    checks++; if (bus.rd_hazard !== 1'b0) begin errors++; $display("FAIL hazard_miss got=%b exp=0", bus.rd_hazard); end
    checks++; if (bus.bank_we !== 4'b1000) begin errors++; $display("FAIL hazard_retire got=%b exp=1000", bus.bank_we); end
    tick();
    bus.rd_valid = 1'b0;
  endtask

  task automatic test_random();
    int rd_pct;
    logic ret;
    logic [3:0] e_we;
    for (int c = 0; c < 400; c++) begin
      rd_pct = (c < 200) ? 85 : 40;
      bus.wr_valid = ($urandom_range(0, 99) < 60);
      bus.wr_addr  = AW'($urandom_range(0, 15));
      bus.wr_data  = $urandom;
      bus.rd_valid = ($urandom_range(0, 99) < rd_pct);
      bus.rd_addr  = AW'($urandom_range(0, 15));
      err_clr      = ($urandom_range(0, 19) == 0);
      #2;
      ret  = m_retire();
      e_we = ret ? (4'b0001 << bank_of(exp_a[0])) : 4'b0000;
      checks++; if (count !== 4'(exp_a.size()) || empty !== (exp_a.size() == 0) ||
                    bus.wr_ready !== (exp_a.size() < DP)) begin
        errors++; $display("FAIL rand_occ c=%0d got count=%0d empty=%b ready=%b exp count=%0d", c,
          count, empty, bus.wr_ready, exp_a.size()); end
      checks++; if (bus.bank_we !== e_we) begin
        errors++; $display("FAIL rand_we c=%0d got=%b exp=%b", c, bus.bank_we, e_we); end
      if (ret) begin
        checks++; if (bus.bank_addr !== exp_a[0][AW-1:2] || bus.bank_wdata !== exp_q[0]) begin
          errors++; $display("FAIL rand_wdata c=%0d got a=%0h d=%0h exp a=%0h d=%0h", c,
            bus.bank_addr, bus.bank_wdata, exp_a[0][AW-1:2], exp_q[0]); end
      end
      checks++; if (bus.rd_hazard !== m_hazard()) begin
        errors++; $display("FAIL rand_hazard c=%0d got=%b exp=%b", c, bus.rd_hazard, m_hazard()); end
      checks++; if (stall_cnt !== 16'(m_stall) || err_ovf !== m_ovf) begin
        errors++; $display("FAIL rand_err c=%0d got stall=%0d ovf=%b exp stall=%0d ovf=%b", c,
          stall_cnt, err_ovf, m_stall, m_ovf); end
      tick();
    end
    drive_idle();
    for (int c = 0; c < DP + 2; c++) tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rand_drain got=%b exp=1", empty); end
  endtask

  task automatic test_reset_mid();
    bus.rd_valid = 1'b1; bus.rd_addr = 14'h020;
    for (int k = 0; k < 5; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = AW'({$urandom_range(1, 4095), 2'b00});
      bus.wr_data  = $urandom;
      tick();
    end
    bus.wr_valid = 1'b0;
    #2;
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL rstmid_pre got=%0d exp=5", count); end
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++; if (empty !== 1'b1 || count !== 4'd0 || bus.bank_we !== 4'b0) begin
      errors++; $display("FAIL rstmid_async got empty=%b count=%0d we=%b exp 1/0/0000", empty, count, bus.bank_we); end
    drive_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #2;
      checks++; if (bus.bank_we !== 4'b0 || empty !== 1'b1) begin
        errors++; $display("FAIL rstmid_stale%0d got we=%b empty=%b exp 0000/1", k, bus.bank_we, empty); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_full();
    test_back_to_back();
    test_hazard();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
